// File: rtl/dds_pkg.sv
// Shared constants for the DDS sine sequencer: default widths and FSM state encoding.
// Imported by the interface, the phase accumulator and the top level.
package dds_pkg;

  localparam int unsigned ADDR_W_DEF  = 10;
  localparam int unsigned DATA_W_DEF  = 14;
  localparam int unsigned PHASE_W_DEF = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_LOAD = 2'd2;

endpackage

// File: rtl/dds_sine_ctrl_if.sv
// Table-load stream, BRAM port pair and sample stream of the DDS sequencer.
// master = the sequencer, slave = the load source / BRAM / sample consumer.
interface dds_sine_ctrl_if
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;
  logic              load_done;
  logic              bram_wr_en;
  logic [ADDR_W-1:0] bram_waddr;
  logic [DATA_W-1:0] bram_wdata;
  logic [ADDR_W-1:0] bram_raddr;
  logic [DATA_W-1:0] bram_rdata;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;

  modport master (
    input  load_data, load_valid, bram_rdata,
    output load_ready, load_done, bram_wr_en, bram_waddr, bram_wdata,
    output bram_raddr, sample_out, sample_valid
  );

  modport slave (
    output load_data, load_valid, bram_rdata,
    input  load_ready, load_done, bram_wr_en, bram_waddr, bram_wdata,
    input  bram_raddr, sample_out, sample_valid
  );

endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator for the DDS: its MSBs plus a phase offset form the registered
// BRAM read address. clr has priority over en; the address holds when not enabled.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [ADDR_W-1:0]  phase_off,
  output logic [ADDR_W-1:0]  addr
);

  logic [PHASE_W-1:0] acc_r;
  logic [ADDR_W-1:0]  addr_r;

  // Issue the current phase as an address, then advance by freq_word (both wrap)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= {PHASE_W{1'b0}};
      addr_r <= {ADDR_W{1'b0}};
    end else if (clr) begin
      acc_r  <= {PHASE_W{1'b0}};
    end else if (en) begin
      addr_r <= acc_r[PHASE_W-1 -: ADDR_W] + phase_off;
      acc_r  <= acc_r + freq_word;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/dds_sine_ctrl.sv
// DDS/NCO sequencer and sine-table manager: sole master of the BRAM ports.
// RUN streams table samples at the accumulator phase; LOAD writes a full new table.
module dds_sine_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [ADDR_W-1:0]  phase_off,
  input  logic               load_start,
  dds_sine_ctrl_if.master    bus,
  output logic [1:0]         state_o
);

  // The extra MSB of the write counter marks "table complete"
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_s;
  logic [ADDR_W:0]   cnt_r;
  logic [ADDR_W:0]   cnt_nxt_s;
  logic              wr_acc_s;
  logic              acc_clr_s;
  logic              acc_en_s;
  logic              finish_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              load_ready_r;
  logic              load_done_r;
  logic              rd_v0_r;
  logic              rd_v1_r;
  logic [DATA_W-1:0] sample_r;
  logic              sample_valid_r;
  logic [ADDR_W-1:0] raddr_s;

  dds_phase_acc #(
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W)
  ) u_phase_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc_clr_s),
    .en        (acc_en_s),
    .freq_word (freq_word),
    .phase_off (phase_off),
    .addr      (raddr_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state: load_start beats start in IDLE, stop beats start in RUN
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) next_s = ST_LOAD;
        else if (start) next_s = ST_RUN;
        else            next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) next_s = ST_IDLE;
        else      next_s = ST_RUN;
      end
      ST_LOAD: begin
        if (cnt_r[ADDR_W]) next_s = ST_IDLE;
        else               next_s = ST_LOAD;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // Per-state datapath controls and next write-counter value
  always_comb begin
    wr_acc_s  = 1'b0;
    acc_clr_s = 1'b0;
    acc_en_s  = 1'b0;
    finish_s  = 1'b0;
    cnt_nxt_s = cnt_r;
    case (state_r)
      ST_IDLE: begin
        acc_clr_s = (next_s == ST_RUN);
        if (load_start) cnt_nxt_s = {(ADDR_W+1){1'b0}};
        else            cnt_nxt_s = cnt_r;
      end
      ST_RUN: begin
        acc_en_s = 1'b1;
      end
      ST_LOAD: begin
        wr_acc_s = bus.load_valid & ~cnt_r[ADDR_W];
        finish_s = cnt_r[ADDR_W];
        if (wr_acc_s) cnt_nxt_s = cnt_r + CNT_ONE;
        else          cnt_nxt_s = cnt_r;
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Load path: write counter, registered BRAM write port and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {(ADDR_W+1){1'b0}};
      wr_en_r      <= 1'b0;
      waddr_r      <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      load_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      wr_en_r      <= wr_acc_s;
      load_ready_r <= (next_s == ST_LOAD) & ~cnt_nxt_s[ADDR_W];
      load_done_r  <= finish_s;
      if (wr_acc_s) begin
        waddr_r <= cnt_r[ADDR_W-1:0];
        wdata_r <= bus.load_data;
      end
    end
  end

  // Read pipeline: issue -> BRAM data -> registered sample, so in-flight reads drain on stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v0_r        <= 1'b0;
      rd_v1_r        <= 1'b0;
      sample_valid_r <= 1'b0;
      sample_r       <= {DATA_W{1'b0}};
    end else begin
      rd_v0_r        <= acc_en_s;
      rd_v1_r        <= rd_v0_r;
      sample_valid_r <= rd_v1_r;
      if (rd_v1_r) begin
        sample_r <= bus.bram_rdata;
      end
    end
  end

  assign bus.load_ready   = load_ready_r;
  assign bus.load_done    = load_done_r;
  assign bus.bram_wr_en   = wr_en_r;
  assign bus.bram_waddr   = waddr_r;
  assign bus.bram_wdata   = wdata_r;
  assign bus.bram_raddr   = raddr_s;
  assign bus.sample_out   = sample_r;
  assign bus.sample_valid = sample_valid_r;
  assign state_o          = state_r;

endmodule

// File: tb/tb_dds_sine_ctrl.sv
// Scoreboard bench for dds_sine_ctrl: a behavioural model predicts table writes and
// samples into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_dds_sine_ctrl;
  import dds_pkg::*;

  localparam int AW = 10;
  localparam int DW = 14;
  localparam int PW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          load_start = 1'b0;
  logic [PW-1:0] freq_word = '0;
  logic [AW-1:0] phase_off = '0;
  logic [1:0]    state_o;

  dds_sine_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dds_sine_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PHASE_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .freq_word  (freq_word),
    .phase_off  (phase_off),
    .load_start (load_start),
    .bus        (bus.master),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // BRAM: registered read with one cycle of latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_wr_en) mem[bus.bram_waddr] <= bus.bram_wdata;
    bus.bram_rdata <= mem[bus.bram_raddr];
  end

  typedef struct packed { logic [DW-1:0] d; int c; } samp_t;
  typedef struct packed { int a; logic [DW-1:0] d; } wr_t;

  samp_t exp_q[$];
  wr_t   wexp_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          cyc = 0;
  int          mode = 0;
  int          cnt = 0;
  bit          exp_done = 1'b0;
  logic [PW-1:0] acc = '0;
  logic [DW-1:0] ref_tbl [DEPTH];
  logic [DW-1:0] src [DEPTH];
  logic [DW-1:0] last_smp = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode, phase and table contents from the rules, one step per clock
  int  m_idx;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mode = 0; acc = '0; cnt = 0; exp_done = 1'b0;
      exp_q.delete(); wexp_q.delete();
    end else begin
      cyc++;
      exp_done = 1'b0;
      case (mode)
        0: begin
          if (load_start) begin mode = 2; cnt = 0; end
          else if (start) begin mode = 1; acc = '0; end
        end
        1: begin
          m_idx = int'(((longint'(acc) >> (PW - AW)) + longint'(phase_off)) % DEPTH);
          exp_q.push_back('{d: ref_tbl[m_idx], c: cyc});
          acc = acc + freq_word;
          if (stop) mode = 0;
        end
        default: begin
          if (cnt == DEPTH) begin
            mode = 0; exp_done = 1'b1;
          end else if (bus.load_valid) begin
            wexp_q.push_back('{a: cnt, d: bus.load_data});
            ref_tbl[cnt] = bus.load_data;
            cnt++;
          end
        end
      endcase
    end
  end

  // Monitor: compare control outputs every cycle, pop writes and samples as they appear
  bit    due;
  wr_t   w;
  samp_t s;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("state", state_o, mode);
      chk("load_ready", bus.load_ready, (mode == 2 && cnt < DEPTH));
      chk("load_done", bus.load_done, exp_done);
      if (bus.load_done) n_done++;
      chk("wr_en", bus.bram_wr_en, wexp_q.size() > 0);
      if (bus.bram_wr_en) n_wr++;
      if (bus.bram_wr_en && wexp_q.size() > 0) begin
        w = wexp_q.pop_front();
        chk("waddr", bus.bram_waddr, w.a);
        chk("wdata", bus.bram_wdata, w.d);
      end
      due = (exp_q.size() > 0) && (exp_q[0].c + 2 <= cyc);
      chk("sample_valid", bus.sample_valid, due);
      if (bus.sample_valid && due) begin
        s = exp_q.pop_front();
        chk("sample_out", bus.sample_out, s.d);
        last_smp = s.d;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {state_o, bus.load_ready, bus.load_done, bus.bram_wr_en, bus.bram_waddr,
             bus.bram_wdata, bus.bram_raddr, bus.sample_out, bus.sample_valid}, 64'd0);
  endtask

  task automatic do_load(input int nwords, input bit gaps);
    int idx = 0;
    int k = 0;
    bit rdy = 1'b0;
    bus.load_valid = 1'b0;
    while (idx < nwords && k < 8000) begin
      @(negedge clk);
      if (bus.load_valid && rdy) idx++;
      k++;
      rdy = bus.load_ready;
      bus.load_valid = (idx < nwords) && !(gaps && (k % 5 == 4));
      bus.load_data = src[idx % DEPTH];
    end
    bus.load_valid = 1'b0;
    if (idx < nwords) chk("load_timeout", idx, nwords);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (state_o != ST_IDLE && k < 20) begin @(negedge clk); k++; end
    chk(nm, state_o, ST_IDLE);
  endtask

  task automatic start_run(input int ncyc);
    int n = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk); n = 1;
    chk("first_raddr", bus.bram_raddr, phase_off);
    while (!bus.sample_valid && n < 10) begin @(negedge clk); n++; end
    chk("first_valid_latency", n, 3);
    tick(ncyc);
  endtask

  task automatic stop_and_drain();
    int nv = 0;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.sample_valid) nv++; end
    chk("drain_valid_count", nv, 2);
    chk("drain_hold", bus.sample_out, last_smp);
  endtask

  int wr0;
  int d0;
  initial begin
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    tick(3);
    chk_reset_outs("reset_outputs");
    rst_n = 1'b1;
    tick(2);

    // Table load with value = address; LOAD must win over a simultaneous start
    for (int i = 0; i < DEPTH; i++) src[i] = DW'(i);
    wr0 = n_wr; d0 = n_done;
    start = 1'b1; load_start = 1'b1; @(negedge clk); start = 1'b0; load_start = 1'b0;
    chk("prio_load_over_start", state_o, ST_LOAD);
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("start_stop_ignored_in_load", state_o, ST_LOAD);
    do_load(DEPTH, 1'b1);
    wait_idle("load1_end_idle");
    tick(2);
    chk("load1_beats", n_wr - wr0, DEPTH);
    chk("load1_done_pulses", n_done - d0, 1);

    // Unit step, wrap past the table end
    freq_word = 32'd1 << 22; phase_off = '0;
    start_run(DEPTH + 8);
    stop_and_drain();

    // Step 2 with offset 512, stop mid-run, restart from the offset
    freq_word = 32'd1 << 23; phase_off = 10'd512;
    start_run(600);
    stop_and_drain();
    start_run(40);

    // load_start ignored in RUN, then stop beats start
    wr0 = n_wr;
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    tick(3);
    chk("load_start_ignored_in_run", state_o, ST_RUN);
    chk("no_write_in_run", n_wr - wr0, 0);
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("stop_beats_start", state_o, ST_IDLE);
    tick(5);

    // Random frequency hopping
    phase_off = AW'($urandom);
    freq_word = $urandom;
    start_run(2);
    repeat (200) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) freq_word = $urandom;
    end
    stop_and_drain();

    // Reset in the middle of a load, then a full random reload
    for (int i = 0; i < DEPTH; i++) src[i] = DW'($urandom);
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    do_load(300, 1'b0);
    rst_n = 1'b0;
    #3;
    chk_reset_outs("midload_reset_outputs");
    tick(2);
    chk_reset_outs("midload_reset_hold");
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < DEPTH; i++) src[i] = DW'($urandom);
    wr0 = n_wr; d0 = n_done;
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    do_load(DEPTH, 1'b1);
    wait_idle("load2_end_idle");
    tick(2);
    chk("load2_beats", n_wr - wr0, DEPTH);
    chk("load2_done_pulses", n_done - d0, 1);

    // Read the random table back at a random rate
    phase_off = AW'($urandom);
    freq_word = $urandom | 32'd1;
    start_run(1500);
    stop_and_drain();

    tick(5);
    chk("sample_queue_empty", exp_q.size(), 0);
    chk("write_queue_empty", wexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_sine_ctrl.md
Name: dds_sine_ctrl

Overview:
Sequencer and table manager for the single-port-pair sine BRAM (1024 x 14-bit signed by default). In RUN it drives a phase accumulator into the BRAM read address and returns a registered sample stream with a valid flag, forming a DDS/NCO. In LOAD it streams a new table into the BRAM write port over a valid/ready handshake. It sits between the control register block and the BRAM instance and is the only master of the BRAM ports.

Parameters:
ADDR_W, 10, BRAM address width; the table depth is 2**ADDR_W.
DATA_W, 14, sample width, two's complement.
PHASE_W, 32, phase accumulator width; must be >= ADDR_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: IDLE -> RUN
stop  in  1  pulse: RUN -> IDLE
freq_word  in  PHASE_W  phase increment, sampled every RUN cycle
phase_off  in  ADDR_W  address offset added to the accumulator MSBs
load_start  in  1  pulse: IDLE -> LOAD
load_data  in  DATA_W  table word
load_valid  in  1  load_data valid
load_ready  out  1  high in LOAD
load_done  out  1  1-cycle pulse after the final table write
bram_wr_en  out  1  to BRAM wr_en
bram_waddr  out  ADDR_W  to BRAM waddr
bram_wdata  out  DATA_W  to BRAM data_in
bram_raddr  out  ADDR_W  to BRAM raddr
bram_rdata  in  DATA_W  from BRAM data_out, registered, 1-cycle latency
sample_out  out  DATA_W  registered sample
sample_valid  out  1  sample_out valid
state_o  out  2  current state: IDLE=0, RUN=1, LOAD=2

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; accumulator 0; write counter 0; read pipeline valids cleared. A reset in the middle of LOAD or RUN aborts immediately. A partial table stays in the BRAM as written.
- IDLE:
  - load_start -> LOAD; clear the write counter.
  - Otherwise start -> RUN; clear the accumulator.
  - If load_start and start are both high, LOAD wins.
  - stop is ignored in IDLE.
- RUN:
  - Each cycle: bram_raddr <= acc[PHASE_W-1 -: ADDR_W] + phase_off, modulo 2**ADDR_W; then acc <= acc + freq_word, modulo 2**PHASE_W.
  - The first issued address is phase_off, since acc=0.
  - stop -> IDLE. If start and stop are both high, stop wins.
  - load_start is ignored in RUN.
- Read pipeline:
  - rd_v0 is high on the cycle a RUN address is registered on bram_raddr.
  - rd_v1 = rd_v0 delayed 1 cycle, aligned with bram_rdata.
  - sample_out <= bram_rdata when rd_v1; sample_valid <= rd_v1.
  - Total latency: address registered at edge N -> sample_valid at edge N+2.
  - On stop, samples already in flight drain: sample_valid stays high exactly 2 more cycles after the last issue. sample_out then holds its last value.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1: bram_wr_en=1, bram_waddr=counter, bram_wdata=load_data, all registered; then counter++.
  - Gaps in load_valid stall the load without limit.
  - The write at counter = 2**ADDR_W-1 is the final write. On the following cycle: load_done=1, state -> IDLE, load_ready=0.
  - start and stop are ignored in LOAD.
  - bram_wr_en is 0 in all other states.
- bram_raddr holds its last value outside RUN.
- Reads and writes never overlap, because the FSM is mutually exclusive.

Decomposition:
- A shared package dds_pkg holds:
  - the state encoding localparams ST_IDLE, ST_RUN, ST_LOAD;
  - the default ADDR_W, DATA_W and PHASE_W constants.
- One sub-module, dds_phase_acc, is natural. It contains the accumulator, the offset adder and the address register, with inputs clr, en, freq_word, phase_off and output addr.
- The FSM, the load counter and the valid pipeline stay in the top level.

Test Plan:
1. Table load:
   - Stimulus: after reset, pulse load_start; stream 1024 words, value = address; deassert load_valid on every 5th cycle.
   - Required response: exactly 1024 wr_en beats at addresses 0..1023; load_done pulses once, 1 cycle after the write to 1023; state returns to 0.
2. Unit step:
   - Stimulus: table from scenario 1; freq_word=2**22, phase_off=0; pulse start.
   - Required response: first sample_valid 2 cycles after the first address issue; sample_out = 0,1,2,…,1023,0,1 (wrap checked).
3. Step 2 with offset:
   - Stimulus: freq_word=2**23, phase_off=512.
   - Required response: samples 512,514,…,1022,0,2,…
4. Stop drain and restart:
   - Stimulus: stop asserted mid-run.
   - Required response: exactly 2 more valid samples, then sample_valid=0. A subsequent start restarts from address phase_off.
5. Priority and ignore rules:
   - Stimulus: start+load_start together in IDLE; start+stop together in RUN; load_start during RUN.
   - Required response: LOAD entered; IDLE entered; the load_start in RUN has no effect and wr_en stays 0.
6. Reset mid-load:
   - Stimulus: rst_n low after 300 load writes, then reload a full table.
   - Required response: all outputs 0 while in reset; the reload starts at waddr 0; the final table reads back correctly in RUN.
